// File: rtl/parity_gen_chk_stream_if.sv
// Stream bundle for parity_gen_chk_stream: input side (word + received
// parity) and output side (word + generated parity + mismatch flag).
// The slave modport is the block's view; master is the surrounding logic.
interface parity_gen_chk_stream_if #(
  parameter int DATA_W = 9
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_par;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_par;
  logic              out_err;

  modport master (
    output in_valid, in_data, in_par, out_ready,
    input  in_ready, out_valid, out_data, out_par, out_err
  );

  modport slave (
    input  in_valid, in_data, in_par, out_ready,
    output in_ready, out_valid, out_data, out_par, out_err
  );
endinterface

// File: rtl/parity_gen_chk_stream.sv
// Streaming parity generator/checker with one registered stage and
// valid/ready on both sides. Each accepted word gets an even/odd parity bit;
// in check mode the received parity is compared and mismatches raise
// out_err, which feeds a sticky status flag on delivery.
// Optional feature macro: PARITY_ERR_CNT_EN adds a saturating delivered-error
// counter err_cnt (CNT_W bits).
module parity_gen_chk_stream #(
  parameter int DATA_W = 9,
  parameter int CNT_W  = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mode_odd,
  input  logic chk_en,
  input  logic err_clr,
  parity_gen_chk_stream_if.slave s,
  output logic err_sticky
`ifdef PARITY_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0] err_cnt
`endif
);

  // Parity bit that makes the total number of ones over {data, par}
  // even (odd_mode=0) or odd (odd_mode=1).
  function automatic logic calc_par(input logic [DATA_W-1:0] d,
                                    input logic odd_mode);
    return (^d) ^ odd_mode;
  endfunction

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic              out_par_q,   out_par_d;
  logic              out_err_q,   out_err_d;
  logic              err_sticky_q, err_sticky_d;

  logic in_hs;
  logic out_hs;
  logic err_evt;
  logic par_new;

  // No skid buffer: accept only when the output register is free or draining.
  assign s.in_ready = rst_n & (~out_valid_q | s.out_ready);
  assign in_hs      = s.in_valid & s.in_ready;
  assign out_hs     = out_valid_q & s.out_ready;
  assign err_evt    = out_hs & out_err_q;
  assign par_new    = calc_par(s.in_data, mode_odd);

  // Output register next state: load on input handshake, else drop valid on drain.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_par_d   = out_par_q;
    out_err_d   = out_err_q;
    if (in_hs) begin
      out_valid_d = 1'b1;
      out_data_d  = s.in_data;
      out_par_d   = par_new;
      out_err_d   = chk_en & (s.in_par != par_new);
    end else if (out_hs) begin
      out_valid_d = 1'b0;
    end
  end

  // Sticky error: a delivered error wins over a same-cycle clear.
  always_comb begin
    err_sticky_d = err_sticky_q;
    if (err_evt) begin
      err_sticky_d = 1'b1;
    end else if (err_clr) begin
      err_sticky_d = 1'b0;
    end
  end

  // Stage 0 -> output register and status update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_par_q    <= 1'b0;
      out_err_q    <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_par_q    <= out_par_d;
      out_err_q    <= out_err_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign s.out_valid = out_valid_q;
  assign s.out_data  = out_data_q;
  assign s.out_par   = out_par_q;
  assign s.out_err   = out_err_q;
  assign err_sticky  = err_sticky_q;

`ifdef PARITY_ERR_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Saturating error count; clear+error in one cycle leaves exactly one.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = err_evt ? CNT_W'(1) : '0;
    end else if (err_evt && (err_cnt_q != CNT_MAX)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_parity_gen_chk_stream.sv
// Scoreboard bench for parity_gen_chk_stream: directed scenarios followed
// by randomized traffic, checked against a behavioural model.
module tb_parity_gen_chk_stream;
  localparam int DATA_W = 9;
  localparam int CNT_W  = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic mode_odd;
  logic chk_en;
  logic err_clr;
  logic err_sticky;
  logic [CNT_W-1:0] err_cnt;

  parity_gen_chk_stream_if #(.DATA_W(DATA_W)) bus ();

  parity_gen_chk_stream #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode_odd   (mode_odd),
    .chk_en     (chk_en),
    .err_clr    (err_clr),
    .s          (bus),
    .err_sticky (err_sticky)
`ifdef PARITY_ERR_CNT_EN
    ,
    .err_cnt    (err_cnt)
`endif
  );

`ifndef PARITY_ERR_CNT_EN
  assign err_cnt = '0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic              p;
    logic              e;
  } word_t;

  word_t sb[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  bit    started = 0;
  bit    m_sticky = 0;
  int    m_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Parity chosen by counting ones: total over {data,par} even or odd.
  function automatic bit ref_par(input logic [DATA_W-1:0] d, input bit odd_mode);
    int ones;
    ones = $countones(d);
    return ((ones % 2) != (odd_mode ? 1 : 0));
  endfunction

  // Monitor: compares the DUT against the model at every negedge, then
  // advances the model by the upcoming rising edge.
  always @(negedge clk) begin
    if (started) begin
      bit    have;
      bit    ohs;
      bit    ihs;
      bit    ev;
      word_t w;
      have = (sb.size() != 0);
      chk("out_valid", bus.out_valid, have);
      chk("in_ready", bus.in_ready, rst_n && (!have || bus.out_ready));
      if (have) begin
        chk("out_data", bus.out_data, sb[0].d);
        chk("out_par",  bus.out_par,  sb[0].p);
        chk("out_err",  bus.out_err,  sb[0].e);
      end
      chk("err_sticky", err_sticky, m_sticky);
`ifdef PARITY_ERR_CNT_EN
      chk("err_cnt", err_cnt, m_cnt);
`endif
      if (!rst_n) begin
        sb.delete();
        m_sticky = 0;
        m_cnt    = 0;
      end else begin
        ohs = have && bus.out_ready;
        ev  = ohs && sb[0].e;
        ihs = bus.in_valid && (!have || bus.out_ready);
        if (ohs) void'(sb.pop_front());
        if (ihs) begin
          w.d = bus.in_data;
          w.p = ref_par(bus.in_data, mode_odd);
          w.e = chk_en && (bus.in_par != w.p);
          sb.push_back(w);
        end
        if (ev) m_sticky = 1;
        else if (err_clr) m_sticky = 0;
        if (err_clr) m_cnt = ev ? 1 : 0;
        else if (ev && m_cnt < CNT_MAX) m_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [DATA_W-1:0] d, input bit odd_mode,
                       input bit ce, input bit p);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    mode_odd     = odd_mode;
    chk_en       = ce;
    bus.in_par   = p;
  endtask

  initial begin
    logic [DATA_W-1:0] d;
    rst_n         = 1'b0;
    mode_odd      = 1'b0;
    chk_en        = 1'b0;
    err_clr       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_par    = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    started = 1;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_data", bus.out_data, '0);
    chk("rst_sticky", err_sticky, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("rst_release_in_ready", bus.in_ready, 1'b1);
    tick();

    // Even/odd generation without checking.
    drive(9'h0A5, 0, 0, 0); tick();
    chk("gen_0A5_even_par", bus.out_par, 1'b0);
    chk("gen_0A5_even_err", bus.out_err, 1'b0);
    drive(9'h0A5, 1, 0, 0); tick();
    chk("gen_0A5_odd_par", bus.out_par, 1'b1);
    drive(9'h1FF, 0, 0, 0); tick();
    chk("gen_1FF_even_par", bus.out_par, 1'b1);
    chk("gen_1FF_even_err", bus.out_err, 1'b0);

    // Check mode.
    drive(9'h001, 0, 1, 1); tick();
    chk("chk_001_err", bus.out_err, 1'b0);
    drive(9'h003, 0, 1, 1); tick();
    chk("chk_003_err", bus.out_err, 1'b1);
    bus.in_valid = 1'b0; tick();
    chk("chk_sticky", err_sticky, 1'b1);
`ifdef PARITY_ERR_CNT_EN
    chk("chk_cnt", err_cnt, 1);
`endif

    // Backpressure.
    bus.out_ready = 1'b0;
    drive(9'h011, 0, 0, 0); tick();
    drive(9'h022, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", bus.in_ready, 1'b0);
      chk("bp_out_data", bus.out_data, 9'h011);
      tick();
    end
    bus.out_ready = 1'b1; tick();
    chk("bp_release_data", bus.out_data, 9'h022);
    for (int i = 0; i < 6; i++) begin
      d = DATA_W'($urandom());
      drive(d, i[0], 0, 0); tick();
      chk("stream_valid", bus.out_valid, 1'b1);
      chk("stream_data", bus.out_data, d);
    end
    bus.in_valid = 1'b0; tick();

    // Saturation then clear.
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      d = DATA_W'($urandom());
      drive(d, 0, 1, !ref_par(d, 0)); tick();
`ifdef PARITY_ERR_CNT_EN
      if (i >= 1) chk("sat_cnt", err_cnt, (i > 3) ? 3 : i);
`endif
    end
    bus.in_valid = 1'b0; tick();
`ifdef PARITY_ERR_CNT_EN
    chk("sat_cnt_last", err_cnt, 3);
`endif
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("clr_sticky", err_sticky, 1'b0);
`ifdef PARITY_ERR_CNT_EN
    chk("clr_cnt", err_cnt, 0);
`endif

    // Clear/set collision.
    for (int i = 0; i < 3; i++) begin
      d = DATA_W'($urandom());
      drive(d, 1, 1, !ref_par(d, 1)); tick();
    end
`ifdef PARITY_ERR_CNT_EN
    chk("coll_cnt_before", err_cnt, 2);
`endif
    bus.in_valid = 1'b0; err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("coll_sticky", err_sticky, 1'b1);
`ifdef PARITY_ERR_CNT_EN
    chk("coll_cnt", err_cnt, 1);
`endif

    // Reset mid-stream while a word is stalled.
    bus.out_ready = 1'b0;
    drive(9'h155, 0, 1, 0); tick();
    chk("rm_held_valid", bus.out_valid, 1'b1);
    drive(9'h0F0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("rm_in_ready_low", bus.in_ready, 1'b0);
    tick();
    chk("rm_out_valid", bus.out_valid, 1'b0);
    chk("rm_sticky", err_sticky, 1'b0);
    chk("rm_out_data", bus.out_data, '0);
`ifdef PARITY_ERR_CNT_EN
    chk("rm_cnt", err_cnt, 0);
`endif
    rst_n = 1'b1;
    #1;
    chk("rm_in_ready_high", bus.in_ready, 1'b1);
    tick();
    chk("rm_first_accept", bus.out_data, 9'h0F0);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    tick();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_data   = DATA_W'($urandom());
      bus.in_par    = 1'($urandom());
      mode_odd      = 1'($urandom());
      chk_en        = 1'($urandom());
      bus.out_ready = ($urandom_range(0, 2) != 0);
      err_clr       = ($urandom_range(0, 15) == 0);
      rst_n         = ($urandom_range(0, 199) != 0);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    err_clr       = 1'b0;
    rst_n         = 1'b1;
    repeat (3) tick();
    chk("drain_empty", bus.out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/parity_gen_chk_stream.md
Name: parity_gen_chk_stream

Overview:
Parametrised streaming parity generator/checker with a 1-stage registered datapath and valid/ready handshake on both sides. Each accepted word is reduced by XOR to produce an even or odd parity bit. In check mode, the computed parity is compared against a received parity bit, and errors are flagged per word and accumulated in sticky status. Sits between a byte/word source and a link or storage interface in the detection chain.

Parameters:
DATA_W, 9, data width in bits covered by parity (>=1)
CNT_W, 8, width of error counter (>=1; used only with PARITY_ERR_CNT_EN)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
mode_odd  input  1  0 = even parity, 1 = odd parity; sampled on input handshake
chk_en  input  1  1 = check in_par against computed parity; sampled on input handshake
in_valid  input  1  input word valid
in_ready  output  1  block can accept a word
in_data  input  DATA_W  input word
in_par  input  1  received parity bit (ignored when chk_en=0)
out_valid  output  1  output word valid
out_ready  input  1  downstream accepts
out_data  output  DATA_W  registered copy of accepted in_data
out_par  output  1  generated parity for out_data
out_err  output  1  parity mismatch for out_data (0 if chk_en was 0)
err_clr  input  1  clear sticky error (and counter when present)
err_sticky  output  1  set by any delivered erroneous word until cleared
err_cnt  output  CNT_W  delivered-error count (present only with PARITY_ERR_CNT_EN)

Behaviour:
- Single clock domain; all state is updated on the rising edge of clk. Reset is synchronous: rst_n=0 at a clock edge resets the state.
- Reset values: out_valid=0, out_data=0, out_par=0, out_err=0, err_sticky=0, err_cnt=0.
- in_ready = rst_n & (~out_valid | out_ready). This is combinational, with no skid buffer.
- Input handshake: in_valid & in_ready at an edge. On a handshake, the output register loads:
  - out_data = in_data
  - out_par = (^in_data) ^ mode_odd
  - out_err = chk_en & (in_par != out_par_new)
  - out_valid = 1
- Output handshake: out_valid & out_ready. If there is no simultaneous input handshake, out_valid goes to 0 and the data/par/err registers hold their last values.
- Simultaneous input and output handshake: the register is replaced by the new word and out_valid stays 1. Throughput is 1 word/cycle and latency is 1 cycle.
- Stall: while out_valid=1 and out_ready=0, out_data/out_par/out_err stay stable and in_ready=0. in_data changes during this time have no effect.
- Parity definition: even mode gives a total number of 1s over {data, par} that is even; odd mode gives an odd total.
- Error event: an output handshake with out_err=1.
  - An error event sets err_sticky.
  - err_clr=1 clears err_sticky, except when an error event occurs in the same cycle. In that case err_sticky ends at 1 (set wins).
- mode_odd and chk_en changes while a word is held do not alter that word's out_par or out_err.
- Reset mid-operation: any held word is discarded with no output handshake, status is cleared, and the first input handshake is possible at the first edge with rst_n=1.
- DATA_W=1: parity equals the data bit XOR mode_odd.

Optional Feature:
PARITY_ERR_CNT_EN — when defined, err_cnt exists and follows these rules:
- increments by 1 on each error event
- saturates at 2^CNT_W-1 (no wrap)
- err_clr alone sets it to 0
- err_clr together with an error event sets it to 1
When the macro is undefined, the err_cnt port and its logic are absent. All other behaviour is identical.

Test Plan:
1. Even/odd generation, DATA_W=9, chk_en=0:
   - in_data=9'h0A5, mode_odd=0 -> out_par=0, one cycle after the handshake.
   - Same word with mode_odd=1 -> out_par=1.
   - in_data=9'h1FF, mode_odd=0 -> out_par=1.
   - out_err=0 in all cases.
2. Check mode, chk_en=1, mode_odd=0:
   - in_data=9'h001 with in_par=1 -> out_err=0.
   - Next word 9'h003 with in_par=1 -> out_err=1; err_sticky=1 after its output handshake; err_cnt=1.
3. Backpressure: send words 9'h011 then 9'h022 with out_ready=0 for 3 cycles.
   - in_ready=0 and out_data=9'h011 stay stable for all 3 cycles.
   - After out_ready=1, 9'h022 appears on the next cycle.
   - With out_ready=1 and in_valid=1 continuously: 1 word per cycle, no bubbles.
4. Saturation, CNT_W=2, macro defined: 5 consecutive erroneous words -> err_cnt reads 1,2,3,3,3. Then err_clr=1 for one cycle with no error -> err_cnt=0 and err_sticky=0.
5. Clear/set collision: err_clr=1 in the same cycle as an error event with err_cnt=2 -> err_sticky=1, err_cnt=1.
6. Reset mid-stream: rst_n=0 for one edge while out_valid=1 and out_ready=0.
   - Next cycle: out_valid=0, err_sticky=0, err_cnt=0.
   - in_ready=0 during reset and 1 after rst_n returns to 1.
